// File: rtl/mips_dmem_responder.sv
// mips_dmem_responder: wait-stated word memory target for the MIPS load/store port.
// Define DMEM_ACCESS_COUNT_EN to add saturating rd_count/wr_count access counters.
module mips_dmem_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
`ifdef DMEM_ACCESS_COUNT_EN
    output logic [15:0] rd_count,
    output logic [15:0] wr_count,
`endif
    output logic        rsp_err
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    localparam logic [3:0] LAT = 4'(LATENCY);

    state_t                state;
    logic [3:0]            cnt;
    logic                  we;
    logic [31:0]           addr;
    logic [31:0]           wdata;
    logic [3:0]            be;
    logic [31:0]           mem [2**ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0] idx;
    logic                  err;
    logic                  access;
    logic                  do_wr;

    assign req_ready = state == IDLE;
    assign idx       = addr[ADDR_WIDTH+1:2];
    assign err       = (addr[1:0] != 2'b00) || (addr[31:ADDR_WIDTH+2] != '0);
    assign access    = state == WAIT && cnt == 4'd0;
    // Gating with rst keeps a reset that lands on the access edge from committing the store
    assign do_wr     = access && we && !err && !rst;

    always_ff @(posedge clk)
        if (req_valid && req_ready) begin
            we    <= req_we;
            addr  <= req_addr;
            wdata <= req_wdata;
            be    <= req_be;
        end

    always_ff @(posedge clk)
        if (do_wr)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    state <= WAIT;
                    cnt   <= LAT;
                end
                WAIT: if (cnt == 4'd0) begin
                    state     <= RESP;
                    rsp_valid <= 1'b1;
                    rsp_err   <= err;
                    rsp_rdata <= (we || err) ? 32'd0 : mem[idx];
                end else begin
                    cnt <= cnt - 4'd1;
                end
                RESP: if (rsp_ready) begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                    rsp_rdata <= 32'd0;
                    rsp_err   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end

`ifdef DMEM_ACCESS_COUNT_EN
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            rd_count <= 16'd0;
            wr_count <= 16'd0;
        end else if (access && !err) begin
            if (we && wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
            if (!we && rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
        end
`endif
endmodule

// File: tb/tb_mips_dmem_responder.sv
// tb_mips_dmem_responder: randomized scoreboard bench for mips_dmem_responder.
// A word-array reference model predicts responses; a negedge monitor checks them.
module tb_mips_dmem_responder;
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [3:0]  req_be = 4'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
`ifdef DMEM_ACCESS_COUNT_EN
    logic [15:0] rd_count;
    logic [15:0] wr_count;
`endif

    int          tests = 0;
    int          fails = 0;
    int          exp_rd = 0;
    int          exp_wr = 0;
    logic [32:0] exp_q[$];
    logic [32:0] mon_e;
    logic [31:0] mdl[16];

    mips_dmem_responder #(.ADDR_WIDTH(10), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
`ifdef DMEM_ACCESS_COUNT_EN
        .rd_count(rd_count), .wr_count(wr_count),
`endif
        .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic req);
        check(name, {31'd0, act}, {31'd0, req});
    endtask

    always @(negedge clk)
        if (!rst && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL rsp_unexpected: got response %h with nothing expected", rsp_rdata);
            end else begin
                mon_e = exp_q.pop_front();
                check("rsp_rdata", rsp_rdata, mon_e[31:0]);
                check1("rsp_err", rsp_err, mon_e[32]);
            end
        end

    task automatic reset_check();
        @(posedge clk) #1 rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check1("rst_req_ready", req_ready, 1'b1);
            check1("rst_rsp_valid", rsp_valid, 1'b0);
            check("rst_rsp_rdata", rsp_rdata, 32'd0);
            check1("rst_rsp_err", rsp_err, 1'b0);
        end
        @(posedge clk) #1 rst = 1'b0;
    endtask

    task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
        int n;
        @(posedge clk) #1;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = wd;
        req_be    = be;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check1("req_accept", req_ready, 1'b1);
        @(posedge clk) #1;
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_be    = 4'($urandom);
    endtask

    task automatic req(input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] be, input int hold);
        logic        err;
        logic [31:0] d;
        logic [31:0] sd;
        logic        se;
        int          n;
        err = (a[1:0] != 2'b00) || (a[31:12] != 20'd0);
        d = 32'd0;
        if (!we && !err) d = mdl[a[5:2]];
        if (we && !err)
            for (int i = 0; i < 4; i++)
                if (be[i]) mdl[a[5:2]][8*i +: 8] = wd[8*i +: 8];
        if (!err) begin
            if (we) exp_wr++;
            else exp_rd++;
        end
        exp_q.push_back({err, d});
        issue(we, a, wd, be);
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("latency", 32'(n), 32'(LAT + 1));
        sd = rsp_rdata;
        se = rsp_err;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check1("hold_valid", rsp_valid, 1'b1);
            check("hold_rdata", rsp_rdata, sd);
            check1("hold_err", rsp_err, se);
            check1("hold_req_ready", req_ready, 1'b0);
        end
        @(posedge clk) #1 rsp_ready = 1'b1;
        @(negedge clk);
        @(posedge clk) #1 rsp_ready = 1'b0;
        @(negedge clk);
        check1("post_rsp_valid", rsp_valid, 1'b0);
        check1("post_req_ready", req_ready, 1'b1);
        check("post_rsp_rdata", rsp_rdata, 32'd0);
        check1("post_rsp_err", rsp_err, 1'b0);
    endtask

    initial begin
        logic [31:0] a;
        int          r;
        reset_check();
        for (int w = 0; w < 16; w++) req(1'b1, 32'(w) << 2, $urandom, 4'hF, 0);
        req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
        req(1'b0, 32'h10, 32'd0, 4'h0, 0);
        req(1'b1, 32'h10, 32'h11223344, 4'b0101, 0);
        req(1'b0, 32'h10, 32'd0, 4'h0, 0);
        req(1'b0, 32'h13, 32'd0, 4'h0, 0);
        req(1'b1, 32'h1000, $urandom, 4'hF, 0);
        req(1'b0, 32'h0, 32'd0, 4'h0, 0);
        req(1'b0, 32'h10, 32'd0, 4'h0, 5);
        req(1'b1, 32'h8, $urandom, 4'h0, 1);
        req(1'b0, 32'h8, 32'd0, 4'h0, 0);
        issue(1'b1, 32'h20, 32'hCAFEF00D, 4'hF);
        @(posedge clk) #1 rst = 1'b1;
        @(negedge clk);
        check1("midwait_req_ready", req_ready, 1'b1);
        check1("midwait_rsp_valid", rsp_valid, 1'b0);
`ifdef DMEM_ACCESS_COUNT_EN
        check("midwait_wr_count", {16'd0, wr_count}, 32'd0);
        exp_wr = 0;
        exp_rd = 0;
`endif
        @(posedge clk) #1 rst = 1'b0;
        req(1'b0, 32'h20, 32'd0, 4'h0, 0);
        for (int k = 0; k < 60; k++) begin
            r = $urandom_range(0, 9);
            a = 32'($urandom_range(0, 15)) << 2;
            if (r == 0) a = a + 32'($urandom_range(1, 3));
            if (r == 1) a = a | (32'd1 << $urandom_range(12, 31));
            req(1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 3));
        end
`ifdef DMEM_ACCESS_COUNT_EN
        check("rd_count", {16'd0, rd_count}, 32'(exp_rd));
        check("wr_count", {16'd0, wr_count}, 32'(exp_wr));
`endif
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
